// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle ALU.
// Opcode encoding, FSM states and a small opcode classification helper.
package alu_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input op_t op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle arithmetic and logic operations of the multicycle ALU.
// Purely combinational; shift and multiply opcodes yield zero here.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = alu_pkg::WIDTH
) (
  input  op_t          i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_carry
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  // Bit W of the widened difference is the borrow, i.e. set iff a < b.
  always_comb begin
    w_sum    = {1'b0, i_a} + {1'b0, i_b};
    w_diff   = {1'b0, i_a} - {1'b0, i_b};
    o_result = {W{1'b0}};
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[W-1:0];
        o_carry  = w_sum[W];
      end
      OP_SUB: begin
        o_result = w_diff[W-1:0];
        o_carry  = w_diff[W];
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      default: begin
        o_result = {W{1'b0}};
        o_carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: IDLE/RUN/DONE sequencer around a single-cycle core,
// a one-bit-per-cycle shifter and an 8-step shift-add multiplier.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  state_t               r_state;
  op_t                  r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2:0]           r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic [2*WIDTH-1:0]   r_mcand;

  logic [WIDTH-1:0]     w_core_res;
  logic                 w_core_cy;
  logic [WIDTH-1:0]     w_sh_next;
  logic                 w_sh_out;
  logic [2*WIDTH-1:0]   w_prod_next;
  logic                 w_last;
  logic [WIDTH-1:0]     w_res;
  logic                 w_cy;

  alu_core #(.W(WIDTH)) u_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_core_res),
    .o_carry  (w_core_cy)
  );

  // Next iteration of shifter and multiplier, and the value latched on leaving RUN.
  always_comb begin
    w_sh_next = r_a;
    w_sh_out  = 1'b0;
    if (r_cnt == 3'd0) begin
      w_sh_next = r_a;
      w_sh_out  = 1'b0;
    end else if (r_op == OP_SHL) begin
      w_sh_next = {r_a[WIDTH-2:0], 1'b0};
      w_sh_out  = r_a[WIDTH-1];
    end else begin
      w_sh_next = {1'b0, r_a[WIDTH-1:1]};
      w_sh_out  = r_a[0];
    end

    if (r_b[0]) begin
      w_prod_next = r_prod + r_mcand;
    end else begin
      w_prod_next = r_prod;
    end

    if (r_op == OP_MUL) begin
      w_last = (r_cnt == 3'd0);
    end else if (is_shift(r_op)) begin
      w_last = (r_cnt <= 3'd1);
    end else begin
      w_last = 1'b1;
    end

    case (r_op)
      OP_SHL, OP_SHR: begin
        w_res = w_sh_next;
        w_cy  = w_sh_out;
      end
      OP_MUL: begin
        w_res = w_prod_next[WIDTH-1:0];
        w_cy  = |w_prod_next[2*WIDTH-1:WIDTH];
      end
      default: begin
        w_res = w_core_res;
        w_cy  = w_core_cy;
      end
    endcase
  end

  // Sequencer with registered status and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_cnt   <= 3'd0;
      r_prod  <= {(2*WIDTH){1'b0}};
      r_mcand <= {(2*WIDTH){1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= {WIDTH{1'b0}};
      carry   <= 1'b0;
      zero    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op    <= op_t'(op);
            r_a     <= a;
            r_b     <= b;
            r_prod  <= {(2*WIDTH){1'b0}};
            r_mcand <= {{WIDTH{1'b0}}, a};
            r_cnt   <= (op_t'(op) == OP_MUL) ? 3'd7 : b[2:0];
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_cnt <= (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
          if (is_shift(r_op)) begin
            r_a <= w_sh_next;
          end else if (r_op == OP_MUL) begin
            r_prod  <= w_prod_next;
            r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
          end else begin
            r_a <= r_a;
          end
          if (w_last) begin
            result  <= w_res;
            carry   <= w_cy;
            zero    <= (w_res == {WIDTH{1'b0}});
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a vector table for every opcode plus
// hand-written sequences for ignored starts and reset during a multiply.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry;
  logic       zero;

  int total;
  int bad;

  typedef struct {
    op_t        op;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    logic [7:0] res;
    logic       cy;
    logic       z;
  } vec_t;

  vec_t vecs[16];

  multicycle_alu dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input string tag, input op_t op_i, input logic [7:0] a_i,
                        input logic [7:0] b_i, input int lat, input logic [7:0] res_e,
                        input logic cy_e, input logic z_e);
    int first_done;
    int n_done;
    int n_busy;
    logic [7:0] cap_res;
    logic cap_cy;
    logic cap_z;
    first_done = 0;
    n_done = 0;
    n_busy = 0;
    cap_res = 8'hxx;
    cap_cy = 1'bx;
    cap_z = 1'bx;
    start = 1'b1;
    op = op_i;
    a = a_i;
    b = b_i;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) begin
          first_done = k;
          cap_res = result;
          cap_cy = carry;
          cap_z = zero;
        end
      end
      if (busy === 1'b1) n_busy++;
    end
    check({tag, ".done_cycle"}, first_done, lat);
    check({tag, ".done_count"}, n_done, 1);
    check({tag, ".busy_cycles"}, n_busy, lat);
    check({tag, ".result"}, cap_res, res_e);
    check({tag, ".carry"}, cap_cy, cy_e);
    check({tag, ".zero"}, cap_z, z_e);
    check({tag, ".result_hold"}, result, res_e);
  endtask

  initial begin
    int nd;
    int first_done;
    logic [7:0] cap_res;
    logic cap_cy;
    total = 0;
    bad = 0;

    vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 2, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 2, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{OP_SUB, 8'h03, 8'h04, 2, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{OP_AND, 8'hF0, 8'h3C, 2, 8'h30, 1'b0, 1'b0};
    vecs[4]  = '{OP_OR,  8'h0F, 8'h30, 2, 8'h3F, 1'b0, 1'b0};
    vecs[5]  = '{OP_XOR, 8'hFF, 8'hFF, 2, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{OP_SHL, 8'h81, 8'h03, 4, 8'h08, 1'b0, 1'b0};
    vecs[7]  = '{OP_SHR, 8'h01, 8'h01, 2, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{OP_SHL, 8'h5A, 8'h00, 2, 8'h5A, 1'b0, 1'b0};
    vecs[9]  = '{OP_SHR, 8'h80, 8'hF7, 8, 8'h01, 1'b0, 1'b0};
    vecs[10] = '{OP_SHL, 8'hC0, 8'h02, 3, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{OP_MUL, 8'h10, 8'h11, 9, 8'h10, 1'b1, 1'b0};
    vecs[12] = '{OP_MUL, 8'h07, 8'h09, 9, 8'h3F, 1'b0, 1'b0};
    vecs[13] = '{OP_MUL, 8'hFF, 8'hFF, 9, 8'h01, 1'b1, 1'b0};
    vecs[14] = '{OP_MUL, 8'h00, 8'h55, 9, 8'h00, 1'b0, 1'b1};
    vecs[15] = '{OP_ADD, 8'hFF, 8'h01, 2, 8'h00, 1'b1, 1'b1};

    reset = 1'b1;
    start = 1'b1;
    op = OP_MUL;
    a = 8'h12;
    b = 8'h34;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset.result", result, 8'h00);
    check("reset.carry", carry, 1'b0);
    check("reset.zero", zero, 1'b1);
    check("reset.done", done, 1'b0);
    check("reset.busy", busy, 1'b0);
    reset = 1'b0;
    start = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
             vecs[i].res, vecs[i].cy, vecs[i].z);
    end

    // Starts pulsed throughout a multiply are ignored until the DUT is idle again.
    nd = 0;
    first_done = 0;
    cap_res = 8'hxx;
    cap_cy = 1'bx;
    start = 1'b1;
    op = OP_MUL;
    a = 8'h10;
    b = 8'h11;
    @(posedge clock);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        nd++;
        if (first_done == 0) begin
          first_done = k;
          cap_res = result;
          cap_cy = carry;
        end
      end
      start = 1'b1;
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
    end
    check("busystart.done_count", nd, 1);
    check("busystart.done_cycle", first_done, 9);
    check("busystart.result", cap_res, 8'h10);
    check("busystart.carry", cap_cy, 1'b1);
    @(negedge clock);
    check("busystart.idle_busy", busy, 1'b0);
    start = 1'b1;
    op = OP_ADD;
    a = 8'h01;
    b = 8'h02;
    @(negedge clock);
    check("busystart.accept_busy", busy, 1'b1);
    check("busystart.accept_done", done, 1'b0);
    start = 1'b0;
    @(negedge clock);
    check("busystart.add_done", done, 1'b1);
    check("busystart.add_result", result, 8'h03);
    @(negedge clock);

    // Reset in the fourth RUN cycle of a multiply aborts it silently.
    nd = 0;
    start = 1'b1;
    op = OP_MUL;
    a = 8'h10;
    b = 8'h11;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (done === 1'b1) nd++;
    end
    reset = 1'b1;
    @(negedge clock);
    check("abort.result", result, 8'h00);
    check("abort.carry", carry, 1'b0);
    check("abort.zero", zero, 1'b1);
    check("abort.busy", busy, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done === 1'b1) nd++;
    end
    check("abort.no_done", nd, 0);
    run_op("abort.add", OP_ADD, 8'h01, 8'h01, 2, 8'h02, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, 8, datapath width; only 8 is supported and verified.
REQ-002 Port: clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-004 Port: start  in  1  request to begin an operation; honoured only in IDLE.
REQ-005 Port: op  in  3  operation code (op_t).
REQ-006 Port: a  in  WIDTH  first operand, driven by the accumulator's data_out.
REQ-007 Port: b  in  WIDTH  second operand, or shift count in b[2:0].
REQ-008 Port: busy  out  1  high while in RUN or DONE.
REQ-009 Port: done  out  1  one-cycle pulse when result is valid; wired to accumulator write_enable.
REQ-010 Port: result  out  WIDTH  operation result; wired to accumulator data_in.
REQ-011 Port: carry  out  1  carry/borrow/shift-out/overflow flag.
REQ-012 Port: zero  out  1  high when result equals 0.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op, a and b, and enter RUN; operand changes after that edge SHALL have no effect.
REQ-015 ADD, SUB, AND, OR, XOR SHALL spend exactly one cycle in RUN, so done rises 2 cycles after the start edge.
REQ-016 SHL/SHR SHALL shift by one bit per RUN cycle for b[2:0] cycles, with a minimum of 1 RUN cycle when the count is 0.
REQ-017 MUL SHALL perform shift-add over exactly 8 RUN cycles.
REQ-018 On leaving RUN, the block SHALL register result, carry and zero together, enter DONE, and assert done for exactly one cycle.
REQ-019 DONE SHALL always return to IDLE on the next edge.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing.
REQ-021 ADD: result = a+b mod 256; carry = bit 8 of the sum.
REQ-022 SUB: result = a-b mod 256; carry = 1 iff a<b (borrow).
REQ-023 AND, OR, XOR: bitwise result; carry = 0.
REQ-024 SHL/SHR: logical shifts with zero fill; carry = the last bit shifted out, or 0 for a count of 0.
REQ-025 MUL: result = low 8 bits of the unsigned product; carry = 1 iff the upper 8 bits are nonzero.
REQ-026 result, carry and zero SHALL hold their values until the next DONE.
REQ-027 busy SHALL be 0 only in IDLE.

Reset
REQ-028 reset=1 SHALL force IDLE on the next edge, aborting any operation in progress without asserting done.
REQ-029 After reset, result=0, carry=0, zero=1, done=0, busy=0, and all internal counters and shift registers SHALL be 0.
REQ-030 reset SHALL take priority over start on the same edge.

Structure
REQ-031 Package alu_pkg SHALL hold op_t (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7), state_t, and the constant WIDTH=8.
REQ-032 Single-cycle ops SHALL live in one combinational sub-module, alu_core; the FSM, shifter and multiplier iteration SHALL stay in multicycle_alu.

Verification
REQ-033 ADD a=0xF0, b=0x20 -> done at start+2, result=0x10, carry=1, zero=0; busy high for 2 cycles.
REQ-034 SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry=0; then a=0x03, b=0x04 -> result=0xFF, carry=1.
REQ-035 SHL a=0x81, b=3 -> done at start+4, result=0x08, carry=0; SHR a=0x01, b=1 -> result=0x00, carry=1, zero=1.
REQ-036 MUL a=0x10, b=0x11 -> done at start+9, result=0x10, carry=1; MUL a=7, b=9 -> result=0x3F, carry=0.
REQ-037 Pulse start every cycle during a MUL, changing a and b -> exactly one done and an unaffected result; the next start is accepted only in IDLE.
REQ-038 reset at cycle 4 of a MUL -> no done; outputs take their reset values; a new ADD 1+1 afterwards -> result=0x02.
